// File: rtl/mod47_pkg.sv
// Shared constants, FSM state type and single-step reduction helper
// for the mod-47 residue datapath.
package mod47_pkg;

    localparam int MOD    = 47;
    localparam int W      = 6;
    localparam int K      = 25;
    localparam int MAXLEN = 16;
    localparam int LEN_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands never exceed 63, so a single conditional subtract fully reduces them.
    function automatic logic [W-1:0] reduce_once(input logic [W-1:0] x);
        return (x >= W'(MOD)) ? x - W'(MOD) : x;
    endfunction

endpackage

// File: rtl/mod47_add.sv
// Combinational modular adder: both inputs already reduced below 47,
// so the 7-bit sum is at most 92 and one conditional subtract suffices.
module mod47_add
    import mod47_pkg::*;
(
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic [W:0] w_sum;
    logic [W:0] w_sumRed;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_sumRed = (w_sum >= (W+1)'(MOD)) ? w_sum - (W+1)'(MOD) : w_sum;
    assign o_sum    = w_sumRed[W-1:0];

endmodule

// File: rtl/mod47_horner_seq.sv
// Horner-rule sequencer: folds a stream of base-25 digits into one residue mod 47,
// using an external constant-multiplier LUT for the K*acc step.
module mod47_horner_seq
    import mod47_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_digit_valid,
    input  logic [W-1:0]     i_digit,
    output logic             o_digit_ready,
    output logic [W-1:0]     o_lut_x,
    input  logic [W-1:0]     i_lut_z,
    output logic             o_res_valid,
    output logic [W-1:0]     o_res,
    input  logic             i_res_ready,
    output logic             o_busy,
    output logic             o_err
);

    state_t           r_state;
    state_t           w_nextState;
    logic [W-1:0]     r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_err;

    logic             w_accept;
    logic             w_digitErr;
    logic             w_lutErr;
    logic             w_lenBad;
    logic [W-1:0]     w_digitRed;
    logic [W-1:0]     w_lutRed;
    logic [W-1:0]     w_sum;

    // Out-of-range digits and LUT results are folded back into range but flagged.
    assign w_digitErr = (i_digit >= W'(MOD));
    assign w_lutErr   = (i_lut_z >= W'(MOD));
    assign w_digitRed = reduce_once(i_digit);
    assign w_lutRed   = reduce_once(i_lut_z);
    assign w_lenBad   = (i_len > LEN_W'(MAXLEN));

    mod47_add u_add (
        .i_a   (w_lutRed),
        .i_b   (w_digitRed),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        o_digit_ready = 1'b0;
        o_res_valid   = 1'b0;
        o_busy        = 1'b1;
        w_accept      = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    // Empty or oversize jobs skip straight to the result.
                    if ((i_len == '0) || w_lenBad) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = RUN;
                    end
                end
            end
            RUN: begin
                o_digit_ready = 1'b1;
                w_accept      = i_digit_valid;
                if (i_digit_valid && (r_cnt == LEN_W'(1))) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && i_start) begin
            r_acc <= '0;
            r_cnt <= i_len;
            r_err <= w_lenBad;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - LEN_W'(1);
            r_err <= r_err | w_digitErr | w_lutErr;
        end
    end

    assign o_lut_x = r_acc;
    assign o_res   = r_acc;
    assign o_err   = r_err;

endmodule

// File: tb/tb_mod47_horner_seq.sv
// Randomized scoreboard bench for mod47_horner_seq with a behavioural Horner model
// and an optionally corruptible 25*x mod 47 LUT.
module tb_mod47_horner_seq;

    typedef struct {
        int res;
        bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] len;
    logic       digitValid;
    logic [5:0] digit;
    logic       digitReady;
    logic [5:0] lutX;
    logic [5:0] lutZ;
    logic       resValid;
    logic [5:0] res;
    logic       resReady;
    logic       busy;
    logic       err;

    int         checks   = 0;
    int         failures = 0;
    exp_t       expQ[$];
    logic [5:0] jobDigits [16];
    bit         corruptEn = 1'b0;
    logic [5:0] corruptOp = 6'd0;

    always #5 clk = ~clk;

    // External LUT model, with one operand optionally forced to an out-of-range value.
    assign lutZ = (corruptEn && lutX == corruptOp) ? 6'd50 : 6'((int'(lutX) * 25) % 47);

    mod47_horner_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_len         (len),
        .i_digit_valid (digitValid),
        .i_digit       (digit),
        .o_digit_ready (digitReady),
        .o_lut_x       (lutX),
        .i_lut_z       (lutZ),
        .o_res_valid   (resValid),
        .o_res         (res),
        .i_res_ready   (resReady),
        .o_busy        (busy),
        .o_err         (err)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Horner reference: value of the digit string in base 25, modulo 47, with error tracking.
    function automatic exp_t refModel(input int n);
        exp_t e;
        int   acc;
        int   z;
        int   d;
        e.res = 0;
        e.err = 1'b0;
        if (n > 16) begin
            e.err = 1'b1;
            return e;
        end
        acc = 0;
        for (int i = 0; i < n; i++) begin
            z = (corruptEn && acc == int'(corruptOp)) ? 50 : (25 * acc) % 47;
            if (z >= 47) begin
                e.err = 1'b1;
                z     = z - 47;
            end
            d = int'(jobDigits[i]);
            if (d >= 47) begin
                e.err = 1'b1;
                d     = d - 47;
            end
            acc = (z + d) % 47;
        end
        e.res = acc;
        return e;
    endfunction

    task automatic startJob(input int n);
        expQ.push_back(refModel(n));
        start = 1'b1;
        len   = 5'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 5'($urandom);
        checkOutput("busyAfterStart", busy, 1);
        if (n >= 1 && n <= 16) begin
            checkOutput("readyAfterStart", digitReady, 1);
        end else begin
            checkOutput("resValidAfterStart", resValid, 1);
            checkOutput("noReadyEmptyJob", digitReady, 0);
        end
    endtask

    task automatic sendDigits(input int first, input int last, input bit gaps);
        for (int i = first; i < last; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            digitValid = 1'b1;
            digit      = jobDigits[i];
            @(posedge clk); #1;
            digitValid = 1'b0;
            digit      = 6'($urandom);
        end
    endtask

    task automatic takeResult(input int delay, input bit poke);
        int waited = 0;
        while (!resValid && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!resValid) begin
            checks++;
            failures++;
            $display("[TB] FAIL resultTimeout actual=res_valid_low expected=res_valid_high at %0t", $time);
            if (expQ.size() > 0) void'(expQ.pop_front());
            return;
        end
        repeat (delay) begin
            if (poke) begin
                start      = 1'b1;
                len        = 5'd2;
                digitValid = 1'b1;
            end
            @(posedge clk); #1;
            start      = 1'b0;
            digitValid = 1'b0;
            checkOutput("heldDuringBackpressure", resValid, 1);
        end
        resReady = 1'b1;
        @(posedge clk); #1;
        resReady = 1'b0;
        checkOutput("idleAfterAccept", busy, 0);
        checkOutput("validLowAfterAccept", resValid, 0);
    endtask

    task automatic applyStimulus(input int n, input bit gaps, input int delay, input bit poke);
        startJob(n);
        if (n >= 1 && n <= 16) begin
            sendDigits(0, n, gaps);
            checkOutput("resValidAfterLast", resValid, 1);
            checkOutput("readyLowAfterLast", digitReady, 0);
        end
        takeResult(delay, poke);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_ready"}, digitReady, 0);
        checkOutput({tag, "_resValid"}, resValid, 0);
        checkOutput({tag, "_res"}, res, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_lutX"}, lutX, 0);
    endtask

    // Scoreboard monitor: pops one expectation per result and checks it stays stable.
    exp_t cur;
    bit   haveRes = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            haveRes = 1'b0;
        end else if (resValid) begin
            if (!haveRes) begin
                haveRes = 1'b1;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    cur.res = -1;
                    $display("[TB] FAIL unexpectedResult actual=%0d expected=none at %0t", res, $time);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("resultValue", res, cur.res);
                    checkOutput("resultErr", err, int'(cur.err));
                end
            end else if (cur.res >= 0) begin
                checkOutput("resHeld", res, cur.res);
                checkOutput("errHeld", err, int'(cur.err));
            end
        end else begin
            haveRes = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        digitValid = 1'b0;
        digit      = '0;
        resReady   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("inReset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkResetOutputs("afterReset");

        $display("[TB] directed: 3,5 -> 33");
        jobDigits[0] = 6'd3; jobDigits[1] = 6'd5;
        applyStimulus(2, 1'b0, 0, 1'b0);

        $display("[TB] directed: single digits 46, 50, then clean job");
        jobDigits[0] = 6'd46;
        applyStimulus(1, 1'b0, 1, 1'b0);
        jobDigits[0] = 6'd50;
        applyStimulus(1, 1'b0, 0, 1'b0);
        jobDigits[0] = 6'd3; jobDigits[1] = 6'd5;
        applyStimulus(2, 1'b0, 0, 1'b0);

        $display("[TB] directed: len 0 and len 17");
        applyStimulus(0, 1'b0, 1, 1'b0);
        applyStimulus(17, 1'b0, 0, 1'b0);

        $display("[TB] directed: 16 x 46 with gaps and backpressure");
        for (int i = 0; i < 16; i++) jobDigits[i] = 6'd46;
        applyStimulus(16, 1'b1, 5, 1'b1);

        $display("[TB] directed: reset mid-run");
        for (int i = 0; i < 16; i++) jobDigits[i] = 6'($urandom_range(0, 46));
        startJob(16);
        sendDigits(0, 7, 1'b0);
        void'(expQ.pop_back());
        rst_n = 1'b0;
        #2;
        checkResetOutputs("asyncAbort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("noResultAfterAbort", resValid, 0);
        jobDigits[0] = 6'd3; jobDigits[1] = 6'd5;
        applyStimulus(2, 1'b0, 0, 1'b0);

        $display("[TB] directed: corrupted LUT operand");
        corruptEn = 1'b1;
        corruptOp = 6'd0;
        applyStimulus(2, 1'b0, 0, 1'b0);
        corruptOp = 6'($urandom_range(1, 46));
        for (int i = 0; i < 16; i++) jobDigits[i] = 6'($urandom_range(0, 46));
        applyStimulus(16, 1'b1, 2, 1'b0);
        corruptEn = 1'b0;

        $display("[TB] random jobs");
        for (int j = 0; j < 10; j++) begin
            bit wide;
            int n;
            wide = ($urandom_range(0, 3) == 0);
            n    = $urandom_range(0, 17);
            for (int i = 0; i < 16; i++) begin
                jobDigits[i] = wide ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 46));
            end
            applyStimulus(n, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
